keypad_digit_loader: RTL

//  Front end of the timer's digit-load interface: turns raw keypad presses (keys 0-9) into
//  one BCD digit plus one active-low, single-cycle loadn strobe per debounced press.

---
 rtl/keypad_digit_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/keypad_digit_loader.sv
// Keypad front end: synchronises raw key lines, debounces a single key press and
// emits one BCD digit with a single-cycle active-low loadn strobe per press.
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 2
) (
  input  logic       CLK,
  input  logic       clearn,
  input  logic [9:0] keys,
  input  logic       enable,
  output logic [3:0] digit,
  output logic       loadn,
  output logic       busy,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LOAD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W:0] DBC = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  logic [9:0]       ks1_q, ks_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       digit_q;
  logic             loadn_q, busy_q;

  logic             valid;
  logic [3:0]       code;
  logic [CNT_W:0]   cnt_inc;

  assign valid   = $onehot(ks_q);
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ks_q[i]) code = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (enable && valid) begin
          cand_d  = code;
          cnt_d   = CNT_W'(1);
          state_d = (DEBOUNCE_CYCLES == 1) ? LOAD : DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!enable || !valid || (code != cand_q)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Counter saturates rather than wrapping back to zero.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_inc[CNT_W-1:0];
          if (cnt_inc >= DBC) state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Any key held, even a different one, keeps us waiting: no auto-repeat.
        if (ks_q == 10'd0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      ks1_q   <= '0;
      ks_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
      digit_q <= 4'd0;
      loadn_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      ks1_q   <= keys;
      ks_q    <= ks1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      // Strobe and digit follow entry into LOAD so the digit is stable while loadn is low.
      loadn_q <= (state_d != LOAD);
      if (state_d == LOAD && state_q != LOAD) digit_q <= cand_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign digit       = digit_q;
  assign loadn       = loadn_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule
